// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Command controller sitting between uartRX/uartTX and the ALU. Decodes command
//   bytes (opcode = byte[7:4], payload = byte[3:0]), writes the ALU operand B and
//   opcode registers, snapshots the ALU result/flags on READ and sequences 1- or
//   2-byte replies through the transmitter's send/busy handshake.
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-high reset
//   rx_data    in   8  byte from uartRX
//   rx_valid   in   1  uartRX valid (level; only the rising edge is used)
//   alu_y      in   4  ALU result Y
//   alu_flags  in   4  ALU flags {Z,N,C,V}
//   tx_busy    in   1  uartTX busy
//   tx_data    out  8  byte to uartTX, held from tx_send until tx_busy falls
//   tx_send    out  1  one-cycle start pulse to uartTX
//   b_out      out  4  ALU operand B register
//   op_out     out  2  ALU opcode register
//   cmd_busy   out  1  high whenever the sequencer is not idle
//   overrun    out  1  sticky: a byte was dropped because the pending slot was full
//   tx_timeout out  1  sticky: tx_busy never rose within TX_TO cycles of tx_send
module uart_cmd_sequencer #(
    parameter int          SETTLE_CYC = 2,
    parameter int          TX_TO      = 16,
    parameter logic [7:0]  NAK_BYTE   = 8'hEE,
    parameter logic [7:0]  PING_BYTE  = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [3:0] alu_y,
    input  logic [3:0] alu_flags,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_send,
    output logic [3:0] b_out,
    output logic [1:0] op_out,
    output logic       cmd_busy,
    output logic       overrun,
    output logic       tx_timeout
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DECODE  = 3'd1;
    localparam logic [2:0] SETTLE  = 3'd2;
    localparam logic [2:0] SEND    = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;
    localparam logic [2:0] WAIT_LO = 3'd5;

    localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TO_W = (TX_TO > 1) ? $clog2(TX_TO) : 1;
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TX_TO - 1);

    logic [2:0]      state;
    logic            rx_prev;
    logic            rx_edge;
    logic            pend_full;
    logic [7:0]      pend_byte;
    logic [7:0]      cmd_byte;
    logic            has_second;
    logic [7:0]      second_byte;
    logic [ST_W-1:0] st_cnt;
    logic [TO_W-1:0] to_cnt;

    assign rx_edge  = rx_valid && !rx_prev;
    assign cmd_busy = (state != IDLE);

    // Byte capture, pending slot, command decode and the reply handshake FSM.
    // In IDLE a waiting pending byte wins over a fresh edge; a fresh edge in that
    // same cycle refills the slot instead of being dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rx_prev     <= 1'b0;
            pend_full   <= 1'b0;
            pend_byte   <= 8'h00;
            cmd_byte    <= 8'h00;
            has_second  <= 1'b0;
            second_byte <= 8'h00;
            st_cnt      <= '0;
            to_cnt      <= '0;
            tx_data     <= 8'h00;
            tx_send     <= 1'b0;
            b_out       <= 4'h0;
            op_out      <= 2'b00;
            overrun     <= 1'b0;
            tx_timeout  <= 1'b0;
        end else begin
            rx_prev <= rx_valid;
            tx_send <= 1'b0;

            if (state == IDLE && pend_full) begin
                if (rx_edge) begin
                    pend_byte <= rx_data;
                end else begin
                    pend_full <= 1'b0;
                end
            end else if (rx_edge && state != IDLE) begin
                if (pend_full) begin
                    overrun <= 1'b1;
                end else begin
                    pend_full <= 1'b1;
                    pend_byte <= rx_data;
                end
            end

            case (state)
                IDLE: begin
                    if (pend_full) begin
                        cmd_byte <= pend_byte;
                        state    <= DECODE;
                    end else if (rx_edge) begin
                        cmd_byte <= rx_data;
                        state    <= DECODE;
                    end
                end

                DECODE: begin
                    has_second <= 1'b0;
                    state      <= SEND;
                    case (cmd_byte[7:4])
                        4'h0: tx_data <= PING_BYTE;
                        4'h1: begin
                            b_out   <= cmd_byte[3:0];
                            tx_data <= {4'hA, cmd_byte[3:0]};
                        end
                        4'h2: begin
                            op_out  <= cmd_byte[1:0];
                            tx_data <= {4'hB, 2'b00, cmd_byte[1:0]};
                        end
                        4'h3: begin
                            st_cnt <= '0;
                            state  <= SETTLE;
                        end
                        default: tx_data <= NAK_BYTE;
                    endcase
                end

                // Give the combinational ALU time to settle before snapshotting.
                SETTLE: begin
                    if (st_cnt == ST_LAST) begin
                        tx_data     <= {4'h0, alu_y};
                        second_byte <= {4'h0, alu_flags};
                        has_second  <= 1'b1;
                        state       <= SEND;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end

                SEND: begin
                    if (!tx_busy) begin
                        tx_send <= 1'b1;
                        to_cnt  <= '0;
                        state   <= WAIT_HI;
                    end
                end

                // A transmitter that never acknowledges is treated as having sent
                // the byte; WAIT_LO then completes as soon as tx_busy is low.
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (TX_TO != 0 && to_cnt == TO_LAST) begin
                        tx_timeout <= 1'b1;
                        state      <= WAIT_LO;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (has_second) begin
                            tx_data    <= second_byte;
                            has_second <= 1'b0;
                            state      <= SEND;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer
//   Directed bench for uart_cmd_sequencer: drives command bytes as rx_valid pulses,
//   models a transmitter that stays busy for a fixed frame after each tx_send and
//   logs every transmitted byte, and models a 4-bit ALU with A fixed at 1
//   (op 0 ADD, 1 AND, 2 SUB, 3 OR).
module tb_uart_cmd_sequencer;

    localparam int         SETTLE_CYC = 2;
    localparam int         TX_TO      = 16;
    localparam int         FRAME_CYC  = 10;
    localparam logic [3:0] ALU_A      = 4'h1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] alu_y;
    logic [3:0] alu_flags;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [3:0] b_out;
    logic [1:0] op_out;
    logic       cmd_busy;
    logic       overrun;
    logic       tx_timeout;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int edge_cyc = 0;
    int base = 0;
    int busy_cnt = 0;
    bit tx_en = 1'b1;

    logic [7:0] tx_log[$];
    int         send_cyc[$];

    uart_cmd_sequencer #(
        .SETTLE_CYC (SETTLE_CYC),
        .TX_TO      (TX_TO),
        .NAK_BYTE   (8'hEE),
        .PING_BYTE  (8'h55)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .alu_y      (alu_y),
        .alu_flags  (alu_flags),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .b_out      (b_out),
        .op_out     (op_out),
        .cmd_busy   (cmd_busy),
        .overrun    (overrun),
        .tx_timeout (tx_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU driven from the DUT's B and opcode registers.
    logic [4:0] alu_sum;
    logic       alu_c;
    logic       alu_v;
    always_comb begin
        alu_sum = 5'd0;
        alu_y   = 4'h0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_out)
            2'd0: begin
                alu_sum = {1'b0, ALU_A} + {1'b0, b_out};
                alu_y   = alu_sum[3:0];
                alu_c   = alu_sum[4];
                alu_v   = (ALU_A[3] == b_out[3]) && (alu_y[3] != ALU_A[3]);
            end
            2'd1: alu_y = ALU_A & b_out;
            2'd2: begin
                alu_sum = {1'b0, ALU_A} + {1'b0, ~b_out} + 5'd1;
                alu_y   = alu_sum[3:0];
                alu_c   = alu_sum[4];
                alu_v   = (ALU_A[3] != b_out[3]) && (alu_y[3] != ALU_A[3]);
            end
            default: alu_y = ALU_A | b_out;
        endcase
        alu_flags = {(alu_y == 4'h0), alu_y[3], alu_c, alu_v};
    end

    // Transmitter model: logs every tx_send and, when enabled, stays busy for a frame.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
            tx_busy  = 1'b0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            if (tx_send) begin
                tx_log.push_back(tx_data);
                send_cyc.push_back(cyc);
                if (tx_en) begin
                    busy_cnt = FRAME_CYC;
                    tx_busy  = 1'b1;
                end
            end
        end
    end

    function automatic logic [7:0] logByte(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'hxx;
    endfunction

    function automatic int sendCyc(input int i);
        if (i < send_cyc.size()) return send_cyc[i];
        return -1000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        edge_cyc = cyc + 1;
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (!cmd_busy) quiet++;
            else quiet = 0;
        end
        checkOutput(tag, (quiet >= 3), 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_tx_send", tx_send, 1'b0);
        checkOutput("rst_b_out", b_out, 4'h0);
        checkOutput("rst_op_out", op_out, 2'b00);
        checkOutput("rst_cmd_busy", cmd_busy, 1'b0);
        checkOutput("rst_flags", {overrun, tx_timeout}, 2'b00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // WR_B 0x17
        base = tx_log.size();
        applyStimulus(8'h17);
        waitIdle("t2_idle", 100);
        checkOutput("t2_b_out", b_out, 4'h7);
        checkOutput("t2_count", tx_log.size() - base, 1);
        checkOutput("t2_byte", logByte(base), 8'hA7);
        checkOutput("t2_latency", sendCyc(base) - edge_cyc, 2);

        // Reset during WAIT_LO with a byte in the pending slot
        applyStimulus(8'h12);
        applyStimulus(8'h1F);
        checkOutput("t1_busy_before", cmd_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t1_rst_outs", {tx_data, tx_send, b_out, op_out, cmd_busy, overrun, tx_timeout}, 20'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        base = tx_log.size();
        applyStimulus(8'h00);
        waitIdle("t1_idle", 100);
        checkOutput("t1_count", tx_log.size() - base, 1);
        checkOutput("t1_byte", logByte(base), 8'h55);
        checkOutput("t1_latency", sendCyc(base) - edge_cyc, 2);
        checkOutput("t1_b_out", b_out, 4'h0);

        // WR_OP 2, WR_B 3, then READ: 1 - 3 = 0xE, flags {Z,N,C,V} = 0100
        base = tx_log.size();
        applyStimulus(8'h22);
        waitIdle("t3_idle_op", 100);
        checkOutput("t3_op_out", op_out, 2'd2);
        checkOutput("t3_op_reply", logByte(base), 8'hB2);
        applyStimulus(8'h13);
        waitIdle("t3_idle_b", 100);
        checkOutput("t3_b_out", b_out, 4'h3);
        checkOutput("t3_b_reply", logByte(base + 1), 8'hA3);
        base = tx_log.size();
        applyStimulus(8'h30);
        waitIdle("t3_idle_read", 100);
        checkOutput("t3_count", tx_log.size() - base, 2);
        checkOutput("t3_y", logByte(base), 8'h0E);
        checkOutput("t3_flags", logByte(base + 1), 8'h04);
        checkOutput("t3_latency", sendCyc(base) - edge_cyc, 2 + SETTLE_CYC);

        // READ, PING queued behind it, third byte overruns the slot
        base = tx_log.size();
        applyStimulus(8'h30);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        waitIdle("t4_idle", 150);
        checkOutput("t4_count", tx_log.size() - base, 3);
        checkOutput("t4_y", logByte(base), 8'h0E);
        checkOutput("t4_flags", logByte(base + 1), 8'h04);
        checkOutput("t4_ping", logByte(base + 2), 8'h55);
        checkOutput("t4_overrun", overrun, 1'b1);
        checkOutput("t4_b_out", b_out, 4'h3);

        // Unknown opcode, then PING
        base = tx_log.size();
        applyStimulus(8'h9C);
        waitIdle("t5_idle_nak", 100);
        checkOutput("t5_nak", logByte(base), 8'hEE);
        checkOutput("t5_regs", {b_out, op_out}, {4'h3, 2'd2});
        applyStimulus(8'h00);
        waitIdle("t5_idle_ping", 100);
        checkOutput("t5_count", tx_log.size() - base, 2);
        checkOutput("t5_ping", logByte(base + 1), 8'h55);
        checkOutput("t5_no_timeout", tx_timeout, 1'b0);

        // Transmitter never goes busy: timeout after TX_TO cycles in WAIT_HI
        tx_en = 1'b0;
        base = tx_log.size();
        applyStimulus(8'h11);
        begin
            int n = 0;
            while (!tx_timeout && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("t6_timeout", tx_timeout, 1'b1);
        checkOutput("t6_to_latency", cyc - sendCyc(base), TX_TO);
        waitIdle("t6_idle", 100);
        checkOutput("t6_byte", logByte(base), 8'hA1);
        checkOutput("t6_b_out", b_out, 4'h1);
        applyStimulus(8'h00);
        waitIdle("t6_idle_next", 100);
        checkOutput("t6_count", tx_log.size() - base, 2);
        checkOutput("t6_next_byte", logByte(base + 1), 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
